// File: rtl/execute_mc_pkg.sv
// execute_mc_pkg
// Shared definitions for the execute stage and its iterative multiply/divide
// unit. It holds the opcode encoding, the iterator FSM states and the operand
// forwarding-select codes.
package execute_mc_pkg;

    // Opcode encoding seen on the decode interface. Any other value executes as ADD.
    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_AND = 5'd2,
        OP_OR  = 5'd3,
        OP_SLL = 5'd4,
        OP_SRA = 5'd5,
        OP_MUL = 5'd6,
        OP_DIV = 5'd7
    } opcode_e;

    // The iterator is either free or working through a MUL/DIV.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Operand forwarding selects. Code 3 is a second alias for the register file.
    localparam logic [1:0] FWD_RF     = 2'd0;
    localparam logic [1:0] FWD_MW     = 2'd1;
    localparam logic [1:0] FWD_EX     = 2'd2;
    localparam logic [1:0] FWD_RF_ALT = 2'd3;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter
// This block is the iterative multiply/divide engine. It is used by execute_mc.
// One iteration runs per cycle, for WIDTH iterations in total.
//   - MUL uses shift-add and returns the low WIDTH bits of the product.
//   - DIV uses signed restoring division on the operand magnitudes. The quotient
//     truncates toward zero. A zero divisor returns all-ones and raises the
//     divide-by-zero flag.
// o_result and o_dz are combinational. They are meaningful in the cycle where
// o_last is high, and they carry the outcome of that final iteration.
// Ports:
//   clock, aclr        clock and async active-high reset
//   i_start            latch the operands and start an operation (only honoured in IDLE)
//   i_abort            drop the operation in flight and return to IDLE
//   i_is_div           select DIV (1) or MUL (0) at start
//   i_a, i_b           operands (A = multiplicand/dividend, B = multiplier/divisor)
//   o_busy, o_last     BUSY state, and the final-iteration cycle
//   o_result, o_dz     result after the current iteration, and the divide-by-zero flag
module muldiv_iter
    import execute_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result,
    output logic             o_dz
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    md_state_e        r_state;
    md_state_e        w_state_n;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg;
    logic             r_dz;
    // r_acc holds the product accumulator for MUL and the partial remainder for DIV.
    // r_x holds the shifting multiplicand for MUL and the divisor magnitude for DIV.
    // r_y holds the shifting multiplier for MUL and the dividend/quotient shifter for DIV.
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;

    logic [WIDTH:0]   w_tmp;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_acc_n;
    logic [WIDTH-1:0] w_x_n;
    logic [WIDTH-1:0] w_y_n;

    // Two's-complement magnitude. The most-negative value maps onto itself,
    // which is still the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (v[WIDTH-1]) begin
            m = (~v) + ONE;
        end else begin
            m = v;
        end
        return m;
    endfunction

    assign o_busy = (r_state == ST_BUSY);
    assign o_last = o_busy & (r_cnt == CNT_LAST);

    // Next state: start from IDLE; leave BUSY on abort or after the final iteration.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_n = ST_BUSY;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (i_abort || o_last) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_state_n = ST_BUSY;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // One iteration of the selected algorithm, computed from the current registers.
    always_comb begin
        // The partial remainder is always below the divisor magnitude (at most
        // 2**(WIDTH-1)), so w_tmp[WIDTH] stays clear. The borrow out of the
        // subtraction is therefore a clean "does not fit" indicator.
        w_tmp   = {r_acc, r_y[WIDTH-1]};
        w_diff  = w_tmp - {1'b0, r_x};
        w_qbit  = ~w_diff[WIDTH];
        w_acc_n = r_acc;
        w_x_n   = r_x;
        w_y_n   = r_y;
        if (r_is_div) begin
            if (w_qbit) begin
                w_acc_n = w_diff[WIDTH-1:0];
            end else begin
                w_acc_n = w_tmp[WIDTH-1:0];
            end
            w_x_n = r_x;
            w_y_n = {r_y[WIDTH-2:0], w_qbit};
        end else begin
            if (r_y[0]) begin
                w_acc_n = r_acc + r_x;
            end else begin
                w_acc_n = r_acc;
            end
            w_x_n = r_x << 1;
            w_y_n = r_y >> 1;
        end
    end

    // Result of the current iteration, with the divide sign fix and zero-divisor override.
    always_comb begin
        o_result = w_acc_n;
        o_dz     = 1'b0;
        if (r_is_div) begin
            o_dz = r_dz;
            if (r_dz) begin
                o_result = {WIDTH{1'b1}};
            end else if (r_neg) begin
                o_result = (~w_y_n) + ONE;
            end else begin
                o_result = w_y_n;
            end
        end else begin
            o_result = w_acc_n;
            o_dz     = 1'b0;
        end
    end

    // Operand latch at start, then one iteration per BUSY cycle. The counter clears on exit.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_cnt    <= {CW{1'b0}};
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_acc    <= {WIDTH{1'b0}};
            r_x      <= {WIDTH{1'b0}};
            r_y      <= {WIDTH{1'b0}};
        end else if (r_state == ST_IDLE) begin
            if (i_start) begin
                r_cnt    <= {CW{1'b0}};
                r_is_div <= i_is_div;
                r_acc    <= {WIDTH{1'b0}};
                if (i_is_div) begin
                    r_neg <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                    r_dz  <= (i_b == {WIDTH{1'b0}});
                    r_x   <= magnitude(i_b);
                    r_y   <= magnitude(i_a);
                end else begin
                    r_neg <= 1'b0;
                    r_dz  <= 1'b0;
                    r_x   <= i_a;
                    r_y   <= i_b;
                end
            end
        end else begin
            if (w_state_n == ST_IDLE) begin
                r_cnt <= {CW{1'b0}};
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            r_acc <= w_acc_n;
            r_x   <= w_x_n;
            r_y   <= w_y_n;
        end
    end

endmodule

// File: rtl/execute_mc.sv
// execute_mc
// This is the execute stage, including the X/M pipeline register.
//   - It has operand forwarding and a single-cycle ALU.
//   - MUL (and DIV, when the divider is built) is iterative and takes WIDTH+1
//     cycles. During that time decode is held through stall_out.
// Configuration macro EXECUTE_MC_DIV_EN:
//   - Defined: DIV is iterative (signed restoring, truncating toward zero).
//   - Undefined: DIV completes in one cycle with result 0 and ex_dz=1, and causes no stall.
// Ports:
//   clock, aclr                     clock and async active-high reset
//   in_valid, flush                 decode valid, and sync kill of the accepted/in-flight op
//   opcode, alu_src, shamt          operation, immediate-B select (forces ADD), shift amount
//   rs_data, rt_data, imm, mw_data  register operands, immediate, M/W forwarding data
//   fwd_a_sel, fwd_b_sel            0/3 regfile, 1 mw_data, 2 ex_result
//   rd_in, reg_wr_in                destination register and write enable
//   stall_out                       decode must hold its inputs (combinational)
//   ex_valid, ex_result, ex_rd, ex_reg_wr, ex_ne, ex_lt, ex_dz   X/M register contents
module execute_mc
    import execute_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [4:0]       opcode,
    input  logic             alu_src,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] mw_data,
    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    input  logic [4:0]       rd_in,
    input  logic             reg_wr_in,
    output logic             stall_out,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_result,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_wr,
    output logic             ex_ne,
    output logic             ex_lt,
    output logic             ex_dz
);

    logic [WIDTH-1:0] w_fwd_a;
    logic [WIDTH-1:0] w_fwd_b;
    logic [WIDTH-1:0] w_opnd_a;
    logic [WIDTH-1:0] w_opnd_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_sra;
    logic             w_sh_big;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_dz;
    logic             w_ne;
    logic             w_lt;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_is_md;
    logic             w_start;
    logic             w_busy;
    logic             w_last;
    logic [WIDTH-1:0] w_md_result;
    logic             w_md_dz;

    // Metadata for the op held in the iterator. It is presented when the op completes.
    logic [4:0]       r_md_rd;
    logic             r_md_wr;
    logic             r_md_ne;
    logic             r_md_lt;

    // Operand A forwarding mux. Selecting ex_result returns whatever X/M holds now.
    always_comb begin
        w_fwd_a = rs_data;
        case (fwd_a_sel)
            FWD_RF, FWD_RF_ALT: w_fwd_a = rs_data;
            FWD_MW:             w_fwd_a = mw_data;
            FWD_EX:             w_fwd_a = ex_result;
            default:            w_fwd_a = rs_data;
        endcase
    end

    // Operand B forwarding mux.
    always_comb begin
        w_fwd_b = rt_data;
        case (fwd_b_sel)
            FWD_RF, FWD_RF_ALT: w_fwd_b = rt_data;
            FWD_MW:             w_fwd_b = mw_data;
            FWD_EX:             w_fwd_b = ex_result;
            default:            w_fwd_b = rt_data;
        endcase
    end

    assign w_opnd_a = w_fwd_a;
    assign w_opnd_b = alu_src ? imm : w_fwd_b;
    assign w_sum    = w_opnd_a + w_opnd_b;
    assign w_sra    = $signed(w_opnd_a) >>> shamt;
    assign w_sh_big = (32'(shamt) >= 32'(WIDTH));
    assign w_ne     = (w_opnd_a != w_opnd_b);
    assign w_lt     = ($signed(w_opnd_a) < $signed(w_opnd_b));

    assign w_is_mul = ~alu_src & (opcode == OP_MUL);
`ifdef EXECUTE_MC_DIV_EN
    assign w_is_div = ~alu_src & (opcode == OP_DIV);
`else
    assign w_is_div = 1'b0;
`endif
    assign w_is_md  = w_is_mul | w_is_div;

    // An op starts in the iterator only from IDLE, and only when it is not being flushed.
    assign w_start   = ~w_busy & in_valid & w_is_md & ~flush;
    // Decode holds through the final iteration's cycle minus one. It advances at the completing edge.
    assign stall_out = w_start | (w_busy & ~w_last);

    // Single-cycle ALU. alu_src forces ADD. MUL/DIV results come from the iterator.
    always_comb begin
        w_alu_res = w_sum;
        w_alu_dz  = 1'b0;
        if (alu_src) begin
            w_alu_res = w_sum;
        end else begin
            case (opcode)
                OP_SUB:  w_alu_res = w_opnd_a - w_opnd_b;
                OP_AND:  w_alu_res = w_opnd_a & w_opnd_b;
                OP_OR:   w_alu_res = w_opnd_a | w_opnd_b;
                OP_SLL:  w_alu_res = w_sh_big ? {WIDTH{1'b0}} : (w_opnd_a << shamt);
                OP_SRA:  w_alu_res = w_sh_big ? {WIDTH{w_opnd_a[WIDTH-1]}} : w_sra;
                OP_MUL:  w_alu_res = {WIDTH{1'b0}};
                OP_DIV: begin
`ifdef EXECUTE_MC_DIV_EN
                    w_alu_res = {WIDTH{1'b0}};
`else
                    // Without a divider, DIV reports divide-by-zero and returns 0.
                    w_alu_res = {WIDTH{1'b0}};
                    w_alu_dz  = 1'b1;
`endif
                end
                default: w_alu_res = w_sum;
            endcase
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clock    (clock),
        .aclr     (aclr),
        .i_start  (w_start),
        .i_abort  (flush),
        .i_is_div (w_is_div),
        .i_a      (w_opnd_a),
        .i_b      (w_opnd_b),
        .o_busy   (w_busy),
        .o_last   (w_last),
        .o_result (w_md_result),
        .o_dz     (w_md_dz)
    );

    // Capture destination and compare flags of a MUL/DIV at the accept edge.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_md_rd <= 5'd0;
            r_md_wr <= 1'b0;
            r_md_ne <= 1'b0;
            r_md_lt <= 1'b0;
        end else if (w_start) begin
            r_md_rd <= rd_in;
            r_md_wr <= reg_wr_in;
            r_md_ne <= w_ne;
            r_md_lt <= w_lt;
        end else begin
            r_md_rd <= r_md_rd;
            r_md_wr <= r_md_wr;
            r_md_ne <= r_md_ne;
            r_md_lt <= r_md_lt;
        end
    end

    // X/M pipeline register. Bubbles clear every field. Flush beats a completing iteration.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            ex_valid  <= 1'b0;
            ex_result <= {WIDTH{1'b0}};
            ex_rd     <= 5'd0;
            ex_reg_wr <= 1'b0;
            ex_ne     <= 1'b0;
            ex_lt     <= 1'b0;
            ex_dz     <= 1'b0;
        end else if (w_busy && w_last && !flush) begin
            ex_valid  <= 1'b1;
            ex_result <= w_md_result;
            ex_rd     <= r_md_rd;
            ex_reg_wr <= r_md_wr;
            ex_ne     <= r_md_ne;
            ex_lt     <= r_md_lt;
            ex_dz     <= w_md_dz;
        end else if (!w_busy && in_valid && !flush && !w_is_md) begin
            ex_valid  <= 1'b1;
            ex_result <= w_alu_res;
            ex_rd     <= rd_in;
            ex_reg_wr <= reg_wr_in;
            ex_ne     <= w_ne;
            ex_lt     <= w_lt;
            ex_dz     <= w_alu_dz;
        end else begin
            ex_valid  <= 1'b0;
            ex_result <= {WIDTH{1'b0}};
            ex_rd     <= 5'd0;
            ex_reg_wr <= 1'b0;
            ex_ne     <= 1'b0;
            ex_lt     <= 1'b0;
            ex_dz     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc
// Directed, self-checking bench for execute_mc (WIDTH=32, SHW=5). Divider
// cases follow EXECUTE_MC_DIV_EN, the same macro the design uses.
module tb_execute_mc;
    import execute_mc_pkg::*;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic              clock = 1'b0;
    logic              aclr;
    logic              in_valid;
    logic              flush;
    logic [4:0]        opcode;
    logic              alu_src;
    logic [SHW-1:0]    shamt;
    logic [WIDTH-1:0]  rs_data;
    logic [WIDTH-1:0]  rt_data;
    logic [WIDTH-1:0]  imm;
    logic [WIDTH-1:0]  mw_data;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [4:0]        rd_in;
    logic              reg_wr_in;
    logic              stall_out;
    logic              ex_valid;
    logic [WIDTH-1:0]  ex_result;
    logic [4:0]        ex_rd;
    logic              ex_reg_wr;
    logic              ex_ne;
    logic              ex_lt;
    logic              ex_dz;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        src;
        logic [31:0] im;
        logic [31:0] res;
        logic        ne;
        logic        lt;
    } alu_vec_t;

    alu_vec_t vecs [11];

    execute_mc #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clock(clock), .aclr(aclr), .in_valid(in_valid), .flush(flush),
        .opcode(opcode), .alu_src(alu_src), .shamt(shamt),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .mw_data(mw_data),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .rd_in(rd_in), .reg_wr_in(reg_wr_in),
        .stall_out(stall_out), .ex_valid(ex_valid), .ex_result(ex_result), .ex_rd(ex_rd),
        .ex_reg_wr(ex_reg_wr), .ex_ne(ex_ne), .ex_lt(ex_lt), .ex_dz(ex_dz)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic present(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        opcode    = op;
        rs_data   = a;
        rt_data   = b;
        in_valid  = 1'b1;
        flush     = 1'b0;
        alu_src   = 1'b0;
        shamt     = 5'd0;
        imm       = 32'd0;
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        rd_in     = 5'd9;
        reg_wr_in = 1'b1;
    endtask

    // Presents a MUL/DIV and counts the stall cycles (bounded). It returns #1 after the edge where ex_valid should rise.
    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n_stall, output int n_vbad);
        @(negedge clock);
        present(op, a, b);
        #1;
        n_stall = 0;
        n_vbad  = 0;
        while (stall_out && n_stall < 100) begin
            @(posedge clock); #1;
            n_stall++;
            if (ex_valid) n_vbad++;
        end
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ex_valid); end
        n_tests++; if (ex_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", ex_result); end
        n_tests++; if ({ex_rd, ex_reg_wr, ex_ne, ex_lt, ex_dz} !== 9'd0) begin n_fail++; $display("FAIL reset_misc: got %b expected 0", {ex_rd, ex_reg_wr, ex_ne, ex_lt, ex_dz}); end
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_out); end
    endtask

    task automatic test_alu();
        vecs[0]  = '{5'd0,  32'd5,          32'd7,      5'd0,  1'b0, 32'd0,   32'd12,         1'b1, 1'b1};
        vecs[1]  = '{5'd0,  32'd4,          32'd4,      5'd0,  1'b0, 32'd0,   32'd8,          1'b0, 1'b0};
        vecs[2]  = '{5'd1,  32'd3,          32'd10,     5'd0,  1'b0, 32'd0,   32'hFFFFFFF9,   1'b1, 1'b1};
        vecs[3]  = '{5'd2,  32'h0000F0F0,   32'h0000FF00, 5'd0, 1'b0, 32'd0,  32'h0000F000,   1'b1, 1'b1};
        vecs[4]  = '{5'd3,  32'h000000F0,   32'h0000000F, 5'd0, 1'b0, 32'd0,  32'h000000FF,   1'b1, 1'b0};
        vecs[5]  = '{5'd4,  32'd1,          32'd0,      5'd31, 1'b0, 32'd0,   32'h80000000,   1'b1, 1'b0};
        vecs[6]  = '{5'd5,  32'h80000000,   32'd0,      5'd31, 1'b0, 32'd0,   32'hFFFFFFFF,   1'b1, 1'b1};
        vecs[7]  = '{5'd5,  32'h7FFFFFF0,   32'd0,      5'd4,  1'b0, 32'd0,   32'h07FFFFFF,   1'b1, 1'b0};
        vecs[8]  = '{5'd1,  32'd1,          32'd55,     5'd0,  1'b1, 32'd100, 32'd101,        1'b1, 1'b1};
        vecs[9]  = '{5'd31, 32'd10,         32'd20,     5'd0,  1'b0, 32'd0,   32'd30,         1'b1, 1'b1};
        vecs[10] = '{5'd4,  32'd3,          32'd3,      5'd0,  1'b0, 32'd0,   32'd3,          1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            present(vecs[i].op, vecs[i].a, vecs[i].b);
            shamt   = vecs[i].sh;
            alu_src = vecs[i].src;
            imm     = vecs[i].im;
            #1;
            n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL alu%0d_stall: got %b expected 0", i, stall_out); end
            @(posedge clock); #1;
            n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL alu%0d_valid: got %b expected 1", i, ex_valid); end
            n_tests++; if (ex_result !== vecs[i].res) begin n_fail++; $display("FAIL alu%0d_result: got %h expected %h", i, ex_result, vecs[i].res); end
            n_tests++; if ({ex_ne, ex_lt} !== {vecs[i].ne, vecs[i].lt}) begin n_fail++; $display("FAIL alu%0d_flags: got ne/lt %b%b expected %b%b", i, ex_ne, ex_lt, vecs[i].ne, vecs[i].lt); end
            n_tests++; if ({ex_rd, ex_reg_wr, ex_dz} !== {5'd9, 1'b1, 1'b0}) begin n_fail++; $display("FAIL alu%0d_meta: got rd %0d wr %b dz %b expected 9 1 0", i, ex_rd, ex_reg_wr, ex_dz); end
        end
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock); #1;
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL alu_idle_valid: got %b expected 0", ex_valid); end
    endtask

    task automatic test_forward();
        @(negedge clock); present(OP_ADD, 32'd5, 32'd7);
        @(posedge clock); #1;
        @(negedge clock); present(OP_SUB, 32'hDEAD, 32'd2); fwd_a_sel = 2'd2;
        @(posedge clock); #1;
        n_tests++; if (ex_result !== 32'd10) begin n_fail++; $display("FAIL fwd_ex_sub: got %h expected %h", ex_result, 32'd10); end
        @(negedge clock); present(OP_AND, 32'd6, 32'hFFFF); fwd_b_sel = 2'd1; mw_data = 32'd3;
        @(posedge clock); #1;
        n_tests++; if (ex_result !== 32'd2) begin n_fail++; $display("FAIL fwd_mw_and: got %h expected %h", ex_result, 32'd2); end
        @(negedge clock); present(OP_ADD, 32'd1, 32'd2); fwd_a_sel = 2'd3; fwd_b_sel = 2'd3; mw_data = 32'd100;
        @(posedge clock); #1;
        n_tests++; if (ex_result !== 32'd3) begin n_fail++; $display("FAIL fwd_rf_alt: got %h expected %h", ex_result, 32'd3); end
        @(negedge clock); in_valid = 1'b0;
    endtask

    task automatic test_mul();
        int ns, nv;
        run_md(OP_MUL, 32'hFFFFFFFD, 32'd7, ns, nv);
        n_tests++; if (ns !== 32) begin n_fail++; $display("FAIL mul_stall_cycles: got %0d expected 32", ns); end
        n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL mul_early_valid: got %0d expected 0", nv); end
        n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL mul_valid: got %b expected 1", ex_valid); end
        n_tests++; if (ex_result !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result: got %h expected %h", ex_result, 32'hFFFFFFEB); end
        n_tests++; if ({ex_rd, ex_reg_wr, ex_ne, ex_lt, ex_dz} !== {5'd9, 1'b1, 1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL mul_meta: got %b expected %b", {ex_rd, ex_reg_wr, ex_ne, ex_lt, ex_dz}, {5'd9, 4'b1110}); end
        @(posedge clock); #1;
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL mul_valid_one_cycle: got %b expected 0", ex_valid); end
        run_md(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, ns, nv);
        n_tests++; if (ex_result !== 32'd1) begin n_fail++; $display("FAIL mul_allones: got %h expected %h", ex_result, 32'd1); end
        run_md(OP_MUL, 32'h12345678, 32'h10, ns, nv);
        n_tests++; if (ex_result !== 32'h23456780) begin n_fail++; $display("FAIL mul_shift: got %h expected %h", ex_result, 32'h23456780); end
        n_tests++; if ({ex_ne, ex_lt} !== 2'b10) begin n_fail++; $display("FAIL mul_flags: got %b expected 10", {ex_ne, ex_lt}); end
    endtask

`ifdef EXECUTE_MC_DIV_EN
    task automatic test_div();
        int ns, nv;
        run_md(OP_DIV, 32'hFFFFFFF9, 32'd2, ns, nv);
        n_tests++; if (ns !== 32) begin n_fail++; $display("FAIL div_stall_cycles: got %0d expected 32", ns); end
        n_tests++; if ({ex_valid, ex_result, ex_dz} !== {1'b1, 32'hFFFFFFFD, 1'b0}) begin n_fail++; $display("FAIL div_neg7_2: got v%b %h dz%b expected v1 fffffffd dz0", ex_valid, ex_result, ex_dz); end
        run_md(OP_DIV, 32'd7, 32'd0, ns, nv);
        n_tests++; if ({ex_valid, ex_result, ex_dz} !== {1'b1, 32'hFFFFFFFF, 1'b1}) begin n_fail++; $display("FAIL div_by_zero: got v%b %h dz%b expected v1 ffffffff dz1", ex_valid, ex_result, ex_dz); end
        run_md(OP_DIV, 32'h80000000, 32'hFFFFFFFF, ns, nv);
        n_tests++; if ({ex_valid, ex_result, ex_dz} !== {1'b1, 32'h80000000, 1'b0}) begin n_fail++; $display("FAIL div_minneg: got v%b %h dz%b expected v1 80000000 dz0", ex_valid, ex_result, ex_dz); end
        run_md(OP_DIV, 32'd100, 32'hFFFFFFF9, ns, nv);
        n_tests++; if (ex_result !== 32'hFFFFFFF2) begin n_fail++; $display("FAIL div_100_neg7: got %h expected %h", ex_result, 32'hFFFFFFF2); end
    endtask
`else
    task automatic test_div_disabled();
        @(negedge clock); present(OP_DIV, 32'd9, 32'd3); #1;
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL divoff_stall: got %b expected 0", stall_out); end
        @(posedge clock); #1;
        n_tests++; if ({ex_valid, ex_result, ex_dz} !== {1'b1, 32'd0, 1'b1}) begin n_fail++; $display("FAIL divoff_result: got v%b %h dz%b expected v1 00000000 dz1", ex_valid, ex_result, ex_dz); end
        @(negedge clock); in_valid = 1'b0;
    endtask
`endif

    task automatic test_flush();
        int bad;
        logic [4:0] md_op;
`ifdef EXECUTE_MC_DIV_EN
        md_op = OP_DIV;
`else
        md_op = OP_MUL;
`endif
        @(negedge clock); present(OP_ADD, 32'd1, 32'd1); flush = 1'b1; #1;
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL flush_alu_stall: got %b expected 0", stall_out); end
        @(posedge clock); #1;
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_alu_valid: got %b expected 0", ex_valid); end
        // Flush at counter 10 (cycle T+11).
        @(negedge clock); present(md_op, 32'd1000, 32'd7);
        repeat (11) @(posedge clock);
        @(negedge clock); flush = 1'b1; in_valid = 1'b0; #1;
        n_tests++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL flush_mid_stall_before: got %b expected 1", stall_out); end
        @(posedge clock); #1;
        n_tests++; if ({stall_out, ex_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_mid_after: got stall/valid %b expected 00", {stall_out, ex_valid}); end
        @(negedge clock); flush = 1'b0;
        bad = 0;
        repeat (36) begin @(posedge clock); #1; if (ex_valid || stall_out) bad++; end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL flush_mid_no_result: got %0d busy/valid cycles expected 0", bad); end
        // Flush in the final-iteration cycle (T+32): the flush takes priority.
        @(negedge clock); present(OP_MUL, 32'd3, 32'd5);
        repeat (32) @(posedge clock);
        @(negedge clock); flush = 1'b1; in_valid = 1'b0; #1;
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL flush_last_stall: got %b expected 0", stall_out); end
        @(posedge clock); #1;
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_last_valid: got %b expected 0", ex_valid); end
        @(negedge clock); flush = 1'b0;
    endtask

    task automatic test_aclr();
        @(negedge clock); present(OP_MUL, 32'd3, 32'd5);
        repeat (6) @(posedge clock);
        @(negedge clock); aclr = 1'b1; in_valid = 1'b0; #1;
        n_tests++; if ({stall_out, ex_valid, ex_result, ex_rd, ex_reg_wr, ex_ne, ex_lt, ex_dz} !== 43'd0) begin n_fail++; $display("FAIL aclr_outputs: got %h expected 0", {stall_out, ex_valid, ex_result, ex_rd, ex_reg_wr, ex_ne, ex_lt, ex_dz}); end
        @(negedge clock); aclr = 1'b0;
        present(OP_ADD, 32'd2, 32'd3); #1;
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL aclr_then_idle_stall: got %b expected 0", stall_out); end
        @(posedge clock); #1;
        n_tests++; if ({ex_valid, ex_result} !== {1'b1, 32'd5}) begin n_fail++; $display("FAIL aclr_then_add: got v%b %h expected v1 00000005", ex_valid, ex_result); end
        @(negedge clock); in_valid = 1'b0;
    endtask

    initial begin
        aclr = 1'b1;
        present(OP_ADD, 32'd0, 32'd0);
        in_valid = 1'b0;
        mw_data  = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        @(negedge clock); aclr = 1'b0;
        test_alu();
        test_forward();
        test_mul();
`ifdef EXECUTE_MC_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_flush();
        test_aclr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
